// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path.
// Holds the opcode constants, the 4-bit ALU operation codes, the datapath
// select encodings (ALU operand A/B, result bus, immediate format), the FSM
// state encoding, and the opcode-class enum with its classifier function.
package riscv_pkg;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operations
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_CONST4 = 2'b10;

    // Result bus select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JALRADR  = 4'd10,
        S_JAL      = 4'd11,
        S_LUI      = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    // Opcode classes seen by the ALU decoder. CLS_NONE covers the legal
    // opcodes with no funct fields (JAL, LUI, AUIPC); CLS_BAD is unknown.
    typedef enum logic [2:0] {
        CLS_BAD    = 3'd0,
        CLS_NONE   = 3'd1,
        CLS_R      = 3'd2,
        CLS_I      = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_LOAD   = 3'd5,
        CLS_STORE  = 3'd6,
        CLS_JALR   = 3'd7
    } op_class_t;

    function automatic op_class_t classify(input logic [6:0] opcode);
        case (opcode)
            OP_R:                     return CLS_R;
            OP_IMM:                   return CLS_I;
            OP_BRANCH:                return CLS_BRANCH;
            OP_LOAD:                  return CLS_LOAD;
            OP_STORE:                 return CLS_STORE;
            OP_JALR:                  return CLS_JALR;
            OP_JAL, OP_LUI, OP_AUIPC: return CLS_NONE;
            default:                  return CLS_BAD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_alu_decoder.sv
// alu_decoder: combinational funct3/funct7 decode.
// Ports:
//   op_class_i  - opcode class (op_class_t encoding)
//   funct3_i    - instr[14:12]
//   funct7_i    - instr[31:25]
//   alu_op_o    - ALU operation for EXECR/EXECI/BRANCH
//   bad_funct_o - funct3/funct7 combination not supported for this class
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [2:0] op_class_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] alu_op_o,
    output logic       bad_funct_o
);

    always_comb begin
        alu_op_o    = ALU_ADD;
        bad_funct_o = 1'b0;
        case (op_class_i)
            CLS_R: begin
                // funct7 must be 0x00, or 0x20 together with funct3 000 (SUB);
                // every other funct7[5] combination is flagged.
                if (funct7_i != 7'h00 && funct7_i != 7'h20) begin
                    bad_funct_o = 1'b1;
                end
                if (funct3_i != 3'b000 && funct7_i[5]) begin
                    bad_funct_o = 1'b1;
                end
                case (funct3_i)
                    3'b000:  alu_op_o = funct7_i[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op_o = ALU_SLL;
                    3'b010:  alu_op_o = ALU_SLT;
                    3'b011:  alu_op_o = ALU_SLTU;
                    3'b100:  alu_op_o = ALU_XOR;
                    3'b101:  alu_op_o = ALU_SRL;
                    3'b110:  alu_op_o = ALU_OR;
                    default: alu_op_o = ALU_AND;
                endcase
            end
            CLS_I: begin
                case (funct3_i)
                    3'b000:  alu_op_o = ALU_ADD;
                    3'b001:  alu_op_o = ALU_SLL;
                    3'b010:  alu_op_o = ALU_SLT;
                    3'b011:  alu_op_o = ALU_SLTU;
                    3'b100:  alu_op_o = ALU_XOR;
                    3'b101:  alu_op_o = ALU_SRL;
                    3'b110:  alu_op_o = ALU_OR;
                    default: alu_op_o = ALU_AND;
                endcase
                // Shift-immediates carry funct7 in the immediate field;
                // anything but 0 (including SRAI) is rejected.
                if ((funct3_i == 3'b001 || funct3_i == 3'b101) && funct7_i != 7'h00) begin
                    bad_funct_o = 1'b1;
                end
            end
            CLS_BRANCH: begin
                case (funct3_i)
                    3'b000, 3'b001: alu_op_o = ALU_SUB;
                    3'b100, 3'b101: alu_op_o = ALU_SLT;
                    3'b110, 3'b111: alu_op_o = ALU_SLTU;
                    default:        bad_funct_o = 1'b1;
                endcase
            end
            CLS_LOAD: begin
                // LB, LH, LW, LBU, LHU
                if (funct3_i == 3'b011 || funct3_i[2:1] == 2'b11) begin
                    bad_funct_o = 1'b1;
                end
            end
            CLS_STORE: begin
                // SB, SH, SW
                if (funct3_i[2] || funct3_i == 3'b011) begin
                    bad_funct_o = 1'b1;
                end
            end
            CLS_JALR: begin
                if (funct3_i != 3'b000) begin
                    bad_funct_o = 1'b1;
                end
            end
            default: begin
                alu_op_o    = ALU_ADD;
                bad_funct_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: multicycle RV32I control FSM.
// Sequences fetch / decode / execute / memory / writeback and drives the
// datapath selects and enables. Outputs are Moore (state + instr), except
// that the fetch and branch enables are qualified by mem_ready / ALU flags.
// Ports:
//   clk, reset (sync, active-high)
//   instr      - instruction register contents
//   zero       - ALU result == 0;   alu_lsb - ALU result bit 0
//   mem_ready  - memory completes the current access this cycle
//   mem_req, mem_we, addr_src      - memory port control
//   ir_write, pc_write, reg_write  - state enables
//   alu_src_a, alu_src_b, alu_op, result_src, imm_src - datapath selects
//   illegal    - sticky unsupported-encoding flag
module control_unit
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        alu_lsb,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic [1:0]  result_src,
    output logic [2:0]  imm_src,
    output logic        illegal
);

    state_t      state_q, state_d;
    logic        illegal_q, illegal_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    op_class_t   op_class;
    logic [3:0]  dec_alu_op;
    logic        bad_funct;
    logic        br_taken;
    logic        unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign op_class      = classify(opcode);
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .op_class_i  (op_class),
        .funct3_i    (funct3),
        .funct7_i    (funct7),
        .alu_op_o    (dec_alu_op),
        .bad_funct_o (bad_funct)
    );

    // Branch condition: EQ/NE use the SUB zero flag, the ordered compares
    // use the SLT/SLTU result bit.
    always_comb begin
        case (funct3)
            3'b000:         br_taken = zero;
            3'b001:         br_taken = !zero;
            3'b100, 3'b110: br_taken = alu_lsb;
            3'b101, 3'b111: br_taken = !alu_lsb;
            default:        br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (op_class == CLS_BAD || bad_funct) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_R:              state_d = S_EXECR;
                        OP_IMM:            state_d = S_EXECI;
                        OP_BRANCH:         state_d = S_BRANCH;
                        OP_JAL:            state_d = S_JAL;
                        OP_JALR:           state_d = S_JALRADR;
                        OP_LUI:            state_d = S_LUI;
                        default:           state_d = S_ALUWB; // AUIPC
                    endcase
                end
            end
            S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_MEMWB:    state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JALRADR:  state_d = S_JAL;
            S_JAL:      state_d = S_ALUWB;
            S_LUI:      state_d = S_ALUWB;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_src   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        imm_src    = IMM_I;
        illegal    = 1'b0;
        // Reset masks everything combinationally so a pending memory write
        // is dropped in the very cycle reset is raised.
        if (!reset) begin
            illegal = illegal_q;
            case (state_q)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_a  = SRCA_PC;
                    alu_src_b  = SRCB_CONST4;
                    result_src = RES_ALU;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    // Branch/jump target (or AUIPC result) lands in ALUOUT.
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    if (opcode == OP_JAL)        imm_src = IMM_J;
                    else if (opcode == OP_AUIPC) imm_src = IMM_U;
                    else                         imm_src = IMM_B;
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                end
                S_MEMREAD: begin
                    mem_req  = 1'b1;
                    addr_src = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = RES_MEM;
                end
                S_MEMWRITE: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    addr_src = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    alu_op    = dec_alu_op;
                end
                S_EXECI: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = dec_alu_op;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    result_src = RES_ALUOUT;
                end
                S_BRANCH: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    alu_op     = dec_alu_op;
                    result_src = RES_ALUOUT;
                    pc_write   = br_taken;
                end
                S_JALRADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                end
                S_JAL: begin
                    // PC takes the target held in ALUOUT while the ALU forms
                    // the link value OLDPC+4 for the following ALUWB.
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_CONST4;
                    result_src = RES_ALUOUT;
                    pc_write   = 1'b1;
                end
                S_LUI: begin
                    alu_src_a = SRCA_ZERO;
                    alu_src_b = SRCB_IMM;
                    imm_src   = IMM_U;
                end
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed and random RV32I instruction streams
// checked cycle by cycle against an instruction-level reference model.
module tb_control_unit;

    localparam int PH_FETCH = 0, PH_DEC = 1, PH_ADDR = 2, PH_RD = 3, PH_RDWB = 4,
                   PH_WR = 5, PH_OPR = 6, PH_OPI = 7, PH_WB = 8, PH_BR = 9,
                   PH_JADDR = 10, PH_LINK = 11, PH_LUI = 12, PH_STOP = 13;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0, alu_lsb = 1'b0, mem_ready = 1'b0;
    logic        mem_req, mem_we, addr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [3:0]  alu_op;
    logic [2:0]  imm_src;
    logic [19:0] obs;

    int   checks = 0;
    int   errors = 0;
    logic exp_ill = 1'b0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .alu_lsb(alu_lsb),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .imm_src(imm_src), .illegal(illegal)
    );

    assign obs = {mem_req, mem_we, addr_src, ir_write, pc_write, reg_write, illegal,
                  alu_src_a, alu_src_b, alu_op, result_src, imm_src};

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // ALU operation named by funct3 (sub selects SUB over ADD).
    function automatic logic [3:0] alu_for(input logic [2:0] f3, input logic sub);
        case (f3)
            3'd0:    return sub ? 4'd1 : 4'd0;
            3'd1:    return 4'd5;
            3'd2:    return 4'd7;
            3'd3:    return 4'd8;
            3'd4:    return 4'd4;
            3'd5:    return 4'd6;
            3'd6:    return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic legal_instr(input logic [31:0] ins);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            7'h33:               return (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd0);
            7'h13:               return (f3 == 3'd1 || f3 == 3'd5) ? (f7 == 7'h00) : 1'b1;
            7'h63:               return !(f3 == 3'd2 || f3 == 3'd3);
            7'h03:               return f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7;
            7'h23:               return f3 <= 3'd2;
            7'h67:               return f3 == 3'd0;
            7'h6F, 7'h37, 7'h17: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    // Expected control word for one cycle of a given instruction phase.
    function automatic logic [19:0] model(input int ph, input logic [31:0] ins,
                                          input logic mr, input logic z, input logic l,
                                          input logic ill);
        logic mq, we, as, irw, pcw, rw, tk;
        logic [1:0] a, b, rs;
        logic [3:0] op;
        logic [2:0] im, f3;
        mq = 0; we = 0; as = 0; irw = 0; pcw = 0; rw = 0;
        a = 0; b = 0; rs = 0; op = 0; im = 0;
        f3 = ins[14:12];
        case (ph)
            PH_FETCH: begin mq = 1; b = 2'd2; rs = 2'd2; irw = mr; pcw = mr; end
            PH_DEC: begin
                a = 2'd1; b = 2'd1;
                im = (ins[6:0] == 7'h6F) ? 3'd4 : (ins[6:0] == 7'h17) ? 3'd3 : 3'd2;
            end
            PH_ADDR:  begin a = 2'd2; b = 2'd1; im = (ins[6:0] == 7'h23) ? 3'd1 : 3'd0; end
            PH_RD:    begin mq = 1; as = 1; end
            PH_RDWB:  begin rw = 1; rs = 2'd1; end
            PH_WR:    begin mq = 1; we = 1; as = 1; end
            PH_OPR:   begin a = 2'd2; b = 2'd0; op = alu_for(f3, ins[30]); end
            PH_OPI:   begin a = 2'd2; b = 2'd1; op = alu_for(f3, 1'b0); end
            PH_WB:    begin rw = 1; end
            PH_BR: begin
                a = 2'd2; b = 2'd0;
                op = (f3[2] == 1'b0) ? 4'd1 : (f3[1] == 1'b0) ? 4'd7 : 4'd8;
                case (f3)
                    3'd0:       tk = z;
                    3'd1:       tk = !z;
                    3'd4, 3'd6: tk = l;
                    default:    tk = !l;
                endcase
                pcw = tk;
            end
            PH_JADDR: begin a = 2'd2; b = 2'd1; end
            PH_LINK:  begin a = 2'd1; b = 2'd2; pcw = 1; end
            PH_LUI:   begin a = 2'd3; b = 2'd1; im = 3'd3; end
            default:  begin mq = 0; end
        endcase
        return {mq, we, as, irw, pcw, rw, ill, a, b, op, rs, im};
    endfunction

    function automatic logic [31:0] gen_legal();
        logic [31:0] ins;
        logic [6:0]  opc;
        for (int t = 0; t < 200; t++) begin
            case ($urandom_range(0, 8))
                0: opc = 7'h33; 1: opc = 7'h13; 2: opc = 7'h63;
                3: opc = 7'h03; 4: opc = 7'h23; 5: opc = 7'h67;
                6: opc = 7'h6F; 7: opc = 7'h37; default: opc = 7'h17;
            endcase
            ins = $urandom;
            ins[6:0] = opc;
            if (opc == 7'h33) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            if (opc == 7'h13 && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5)) ins[31:25] = 7'h00;
            if (legal_instr(ins)) return ins;
        end
        return 32'h002081B3;
    endfunction

    // Sample at the falling edge, then advance to just past the next rise.
    task automatic chk(input logic [19:0] exp, input string tag);
        @(negedge clk);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ph, input logic mr, input logic z, input logic l,
                         input string tag);
        mem_ready = mr;
        zero      = z;
        alu_lsb   = l;
        chk(model(ph, instr, mr, z, l, exp_ill), $sformatf("%s/ph%0d", tag, ph));
    endtask

    // Run one instruction; nwait < 0 randomizes memory stalls, zsel/lsel < 0
    // randomize the ALU flags.
    task automatic run_instr(input logic [31:0] ins, input int nwait, input int zsel,
                             input int lsel, input string tag);
        int   phs[$];
        int   nw;
        logic z, l;
        instr = ins;
        case (ins[6:0])
            7'h33:   phs = '{PH_FETCH, PH_DEC, PH_OPR, PH_WB};
            7'h13:   phs = '{PH_FETCH, PH_DEC, PH_OPI, PH_WB};
            7'h03:   phs = '{PH_FETCH, PH_DEC, PH_ADDR, PH_RD, PH_RDWB};
            7'h23:   phs = '{PH_FETCH, PH_DEC, PH_ADDR, PH_WR};
            7'h63:   phs = '{PH_FETCH, PH_DEC, PH_BR};
            7'h6F:   phs = '{PH_FETCH, PH_DEC, PH_LINK, PH_WB};
            7'h67:   phs = '{PH_FETCH, PH_DEC, PH_JADDR, PH_LINK, PH_WB};
            7'h37:   phs = '{PH_FETCH, PH_DEC, PH_LUI, PH_WB};
            7'h17:   phs = '{PH_FETCH, PH_DEC, PH_WB};
            default: phs = '{PH_FETCH, PH_DEC};
        endcase
        if (!legal_instr(ins)) phs = '{PH_FETCH, PH_DEC};
        foreach (phs[i]) begin
            z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            l = (lsel < 0) ? 1'($urandom_range(0, 1)) : 1'(lsel);
            if (phs[i] == PH_FETCH || phs[i] == PH_RD || phs[i] == PH_WR) begin
                nw = (nwait < 0) ? $urandom_range(0, 2) : nwait;
                for (int w = 0; w < nw; w++) drive(phs[i], 1'b0, z, l, tag);
                drive(phs[i], 1'b1, z, l, tag);
            end else begin
                drive(phs[i], 1'($urandom_range(0, 1)), z, l, tag);
            end
        end
        if (!legal_instr(ins)) exp_ill = 1'b1;
    endtask

    initial begin
        // Reset: all outputs forced low while reset is high.
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b1; alu_lsb = 1'b1;
        @(posedge clk); #1;
        chk(20'h0, "reset_a");
        chk(20'h0, "reset_b");
        reset = 1'b0;

        // Directed instructions.
        run_instr(32'h002081B3, 0, -1, -1, "add");
        run_instr(32'h402081B3, 0, -1, -1, "sub");
        run_instr(32'h0010B193, 0, -1, -1, "sltiu");
        run_instr(32'h0000A183, 3, -1, -1, "lw_wait3");
        run_instr(32'h00208463, 0, 1, -1, "beq_taken");
        run_instr(32'h00208463, 0, 0, -1, "beq_not");
        run_instr(32'h0020F463, 0, -1, 0, "bgeu_taken");
        run_instr(32'h0020C463, 0, -1, 1, "blt_taken");
        run_instr(32'h0020A023, 2, -1, -1, "sw_wait2");
        run_instr(32'h008000EF, 0, -1, -1, "jal");
        run_instr(32'h000100E7, 1, -1, -1, "jalr");
        run_instr(32'h123451B7, 0, -1, -1, "lui");
        run_instr(32'h00001197, 0, -1, -1, "auipc");
        run_instr(32'h0020D1B3, 0, -1, -1, "srl");

        // Random legal stream with random stalls.
        for (int k = 0; k < 60; k++) begin
            run_instr(gen_legal(), -1, -1, -1, $sformatf("rnd%0d", k));
        end

        // Reset while a store waits on memory.
        instr = 32'h0020A023;
        drive(PH_FETCH, 1'b1, 1'b0, 1'b0, "swr");
        drive(PH_DEC, 1'b1, 1'b0, 1'b0, "swr");
        drive(PH_ADDR, 1'b0, 1'b0, 1'b0, "swr");
        drive(PH_WR, 1'b0, 1'b0, 1'b0, "swr");
        drive(PH_WR, 1'b0, 1'b0, 1'b0, "swr");
        reset = 1'b1; mem_ready = 1'b0;
        chk(20'h0, "swr_reset_edge");
        mem_ready = 1'b1;
        chk(20'h0, "swr_reset_hold");
        reset = 1'b0;
        drive(PH_FETCH, 1'b0, 1'b0, 1'b0, "swr_resume");
        run_instr(32'h002081B3, 0, -1, -1, "add_after_swr");

        // SRA is unsupported: halt with illegal set, nothing enabled.
        run_instr(32'h4020D1B3, 0, -1, -1, "sra");
        for (int c = 0; c < 20; c++) begin
            drive(PH_STOP, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), "halt");
        end
        reset = 1'b1;
        chk(20'h0, "halt_reset");
        reset = 1'b0;
        exp_ill = 1'b0;
        run_instr(32'h002081B3, 1, -1, -1, "add_after_halt");

        // Unknown opcode and SRAI also halt.
        run_instr(32'h0000007F, 0, -1, -1, "bad_opcode");
        for (int c = 0; c < 3; c++) drive(PH_STOP, 1'b1, 1'b0, 1'b0, "halt2");
        reset = 1'b1;
        chk(20'h0, "halt2_reset");
        reset = 1'b0;
        exp_ill = 1'b0;
        run_instr(32'h4010D193, 0, -1, -1, "srai");
        drive(PH_STOP, 1'b1, 1'b0, 1'b0, "halt3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
